// File: rtl/slow_clk_meter_pkg.sv
// Shared types and constants for the slow clock frequency meter.
//
// Contents:
//   state_e           measurement FSM states (idle, arm, gate, done)
//   filter_len        consecutive identical samples the optional glitch filter needs
//   calc_gate_cycles  fast-clock cycles in one gate window
package slow_clk_meter_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StArm,
    StGate,
    StDone
  } state_e;

  localparam int unsigned filter_len = 3;

  // Number of system clock cycles in one gate window of gate_ms milliseconds.
  function automatic int unsigned calc_gate_cycles(input int unsigned fast_clk_mhz,
                                                   input int unsigned gate_ms);
    return fast_clk_mhz * 1000 * gate_ms;
  endfunction

endpackage

// File: rtl/slow_clk_meter_sync_edge_detect.sv
// Synchronizer, optional glitch filter and rising-edge detector for the measured input.
//
// Ports:
//   clk         in   system clock
//   rst         in   synchronous active-high reset
//   meas_clk    in   asynchronous slow signal to measure
//   edge_pulse  out  one-cycle pulse per detected rising edge
//
// Build option: define SLOW_CLK_METER_FILTER_EN to insert a glitch filter that only changes
// level after filter_len consecutive identical synced samples (adds filter_len cycles latency).
module slow_clk_meter_sync_edge_detect
  import slow_clk_meter_pkg::*;
#(
  parameter int unsigned sync_stages = 2  // at least 2
) (
  input  logic clk,
  input  logic rst,
  input  logic meas_clk,
  output logic edge_pulse
);

  logic [sync_stages-1:0] sync_q;
  logic                   synced;
  logic                   level;
  logic                   prev_q;
  logic                   edge_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[sync_stages-2:0], meas_clk};
    end
  end

  assign synced = sync_q[sync_stages-1];

`ifdef SLOW_CLK_METER_FILTER_EN
  // The current synced sample plus the previous filter_len-1 samples form the vote window,
  // so a new level is accepted exactly filter_len cycles after it first appears.
  logic [filter_len-2:0] hist_q;
  logic                  filt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      hist_q <= '0;
      filt_q <= 1'b0;
    end else begin
      hist_q <= {hist_q[filter_len-3:0], synced};
      if (synced && (&hist_q)) begin
        filt_q <= 1'b1;
      end else if (!synced && !(|hist_q)) begin
        filt_q <= 1'b0;
      end
    end
  end

  assign level = filt_q;
`else
  assign level = synced;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q <= 1'b0;
      edge_q <= 1'b0;
    end else begin
      prev_q <= level;
      edge_q <= level & ~prev_q;
    end
  end

  assign edge_pulse = edge_q;

endmodule

// File: rtl/slow_clk_meter.sv
// Slow clock frequency meter: counts rising edges of meas_clk over a gate window timed by clk.
// With gate_ms = 1000 the reported count is the input frequency in Hz.
//
// Ports:
//   clk         in   system clock (fast_clk_mhz MHz)
//   rst         in   synchronous active-high reset
//   meas_clk    in   asynchronous signal to measure (must stay below clk/4)
//   start       in   single-cycle request for one measurement (ignored while busy)
//   continuous  in   level; while high, measurements repeat back-to-back
//   busy        out  high while a measurement is in progress (arm, gate, done)
//   edge_pulse  out  one-cycle pulse per detected rising edge of meas_clk
//   freq_valid  out  one-cycle pulse when a new result is presented
//   freq_count  out  last completed edge count, held until the next result
//   overflow    out  result saturated; updated together with freq_count
//
// Build option: SLOW_CLK_METER_FILTER_EN enables the input glitch filter in the edge detector.
module slow_clk_meter
  import slow_clk_meter_pkg::*;
#(
  parameter int unsigned fast_clk_mhz = 50,
  parameter int unsigned gate_ms      = 1000,
  parameter int unsigned w_count      = 32,
  parameter int unsigned sync_stages  = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               meas_clk,
  input  logic               start,
  input  logic               continuous,
  output logic               busy,
  output logic               edge_pulse,
  output logic               freq_valid,
  output logic [w_count-1:0] freq_count,
  output logic               overflow
);

  localparam int unsigned gate_cycles = calc_gate_cycles(fast_clk_mhz, gate_ms);
  localparam int unsigned gate_w      = $clog2(gate_cycles + 1);
  localparam logic [gate_w-1:0] gate_load = gate_w'(gate_cycles - 1);

  state_e               state_q, state_d;
  logic [gate_w-1:0]    gate_q, gate_d;
  logic [w_count-1:0]   cnt_q, cnt_d;
  logic                 ovf_q, ovf_d;
  logic [w_count-1:0]   freq_count_q, freq_count_d;
  logic                 overflow_q, overflow_d;
  logic                 freq_valid_q, freq_valid_d;

  slow_clk_meter_sync_edge_detect #(
    .sync_stages(sync_stages)
  ) u_sync_edge_detect (
    .clk       (clk),
    .rst       (rst),
    .meas_clk  (meas_clk),
    .edge_pulse(edge_pulse)
  );

  always_comb begin
    state_d      = state_q;
    gate_d       = gate_q;
    cnt_d        = cnt_q;
    ovf_d        = ovf_q;
    freq_count_d = freq_count_q;
    overflow_d   = overflow_q;
    freq_valid_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start || continuous) begin
          state_d = StArm;
        end
      end

      StArm: begin
        cnt_d   = '0;
        ovf_d   = 1'b0;
        gate_d  = gate_load;
        state_d = StGate;
      end

      StGate: begin
        if (edge_pulse) begin
          if (&cnt_q) begin
            ovf_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        if (gate_q == '0) begin
          // Last gate cycle: capture the result (including an edge on this cycle) so that
          // freq_count, overflow and freq_valid are all visible during the done cycle.
          state_d      = StDone;
          freq_count_d = cnt_d;
          overflow_d   = ovf_d;
          freq_valid_d = 1'b1;
        end else begin
          gate_d = gate_q - 1'b1;
        end
      end

      StDone: begin
        state_d = continuous ? StArm : StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      gate_q       <= '0;
      cnt_q        <= '0;
      ovf_q        <= 1'b0;
      freq_count_q <= '0;
      overflow_q   <= 1'b0;
      freq_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      gate_q       <= gate_d;
      cnt_q        <= cnt_d;
      ovf_q        <= ovf_d;
      freq_count_q <= freq_count_d;
      overflow_q   <= overflow_d;
      freq_valid_q <= freq_valid_d;
    end
  end

  assign busy       = (state_q != StIdle);
  assign freq_valid = freq_valid_q;
  assign freq_count = freq_count_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_slow_clk_meter.sv
// Bench for slow_clk_meter with fast_clk_mhz=1, gate_ms=1 (1000-cycle gate window).
module tb_slow_clk_meter;

  localparam int unsigned Gate = 1000;
  localparam int unsigned Lat  = Gate + 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        meas_clk;
  logic        start;
  logic        continuous;
  logic        busy;
  logic        edge_pulse;
  logic        freq_valid;
  logic [31:0] freq_count;
  logic        overflow;

  logic        sat_start;
  logic        sat_cont;
  logic        sat_busy;
  logic        sat_edge;
  logic        sat_valid;
  logic [3:0]  sat_count;
  logic        sat_ovf;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  // Input pattern: 0 = constant low, 1 = periodic, 2 = period-10 with a 2-cycle glitch.
  int unsigned pat_mode   = 0;
  int unsigned pat_period = 10;
  int unsigned pat_high   = 5;
  int unsigned pat_phase  = 0;
  int unsigned tick       = 0;

  int unsigned lat, nvalid, npulse, expct;
  int unsigned periods[6] = '{8, 10, 20, 25, 40, 50};

  slow_clk_meter #(
    .fast_clk_mhz(1),
    .gate_ms     (1),
    .w_count     (32),
    .sync_stages (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .meas_clk  (meas_clk),
    .start     (start),
    .continuous(continuous),
    .busy      (busy),
    .edge_pulse(edge_pulse),
    .freq_valid(freq_valid),
    .freq_count(freq_count),
    .overflow  (overflow)
  );

  slow_clk_meter #(
    .fast_clk_mhz(1),
    .gate_ms     (1),
    .w_count     (4),
    .sync_stages (2)
  ) dut_sat (
    .clk       (clk),
    .rst       (rst),
    .meas_clk  (meas_clk),
    .start     (sat_start),
    .continuous(sat_cont),
    .busy      (sat_busy),
    .edge_pulse(sat_edge),
    .freq_valid(sat_valid),
    .freq_count(sat_count),
    .overflow  (sat_ovf)
  );

  always #5 clk = ~clk;

  function automatic logic pat_level(input int unsigned t);
    int unsigned p;
    case (pat_mode)
      1: return ((t + pat_phase) % pat_period) < pat_high;
      2: begin
        p = t % 10;
        return (p < 4) || (p == 7) || (p == 8);
      end
      default: return 1'b0;
    endcase
  endfunction

  // Rising edges per period of the periodic pattern, from the waveform itself.
  function automatic int unsigned rises_per_period();
    int unsigned r = 0;
    for (int unsigned t = 0; t < pat_period; t++) begin
      if (pat_level(t + pat_period) && !pat_level(t + pat_period - 1)) r++;
    end
    return r;
  endfunction

  initial begin
    meas_clk = 1'b0;
    forever begin
      @(negedge clk);
      tick++;
      meas_clk = pat_level(tick);
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Call on the negedge where start/continuous was just driven (k=0). Returns on the
  // negedge where freq_valid is seen; lat=0 means it never came within the limit.
  task automatic run_until_valid(input int unsigned limit, input int unsigned poke_at,
                                 input int unsigned drop_at, output int unsigned lat_o,
                                 output int unsigned npulse_o);
    lat_o = 0;
    npulse_o = 0;
    for (int unsigned k = 1; k <= limit; k++) begin
      step();
      start = 1'b0;
      if (k >= 2 && k <= Gate + 1 && edge_pulse) npulse_o++;
      if (freq_valid) begin
        lat_o = k;
        break;
      end
      if (k == poke_at) start = 1'b1;
      if (k == drop_at) continuous = 1'b0;
    end
  endtask

  task automatic count_valids(input int unsigned n, output int unsigned nv);
    nv = 0;
    for (int unsigned k = 0; k < n; k++) begin
      step();
      if (freq_valid) nv++;
    end
  endtask

  task automatic settle();
    for (int unsigned k = 0; k < 20; k++) step();
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    continuous = 1'b0;
    sat_start = 1'b0;
    sat_cont = 1'b0;
    pat_mode = 1;
    pat_period = 4;
    pat_high = 2;

    // Reset held while the input toggles.
    for (int unsigned k = 0; k < 5; k++) begin
      step();
      check("reset_flags", {28'b0, busy, edge_pulse, freq_valid, overflow}, 32'd0);
      check("reset_count", freq_count, 32'd0);
    end
    rst = 1'b0;

    // Single shot, period 10.
    pat_period = 10;
    pat_high = 5;
    settle();
    start = 1'b1;
    run_until_valid(Lat + 100, 0, 0, lat, npulse);
    check("single_latency", lat, Lat);
    check("single_count", freq_count, 32'd100);
    check("single_overflow", 32'(overflow), 32'd0);
    check("single_edge_pulses", npulse, 32'd100);
    step();
    check("single_busy_after", 32'(busy), 32'd0);
    count_valids(30, nvalid);
    check("single_one_result", nvalid, 32'd0);

    // Randomized single shots over periods that divide the gate window.
    for (int i = 0; i < 4; i++) begin
      pat_period = periods[$urandom_range(0, 5)];
      pat_high = 3 + $urandom_range(0, pat_period - 6);
      pat_phase = $urandom_range(0, pat_period - 1);
      expct = (Gate / pat_period) * rises_per_period();
      settle();
      start = 1'b1;
      run_until_valid(Lat + 100, 0, 0, lat, npulse);
      check("rand_latency", lat, Lat);
      check("rand_count", freq_count, expct);
      check("rand_edge_pulses", npulse, expct);
    end

    // Continuous mode, period 20; drop continuous midway through the third window.
    pat_period = 20;
    pat_high = 10;
    pat_phase = 0;
    settle();
    continuous = 1'b1;
    for (int w = 0; w < 3; w++) begin
      run_until_valid(Lat + 100, 0, (w == 2) ? 500 : 0, lat, npulse);
      check("cont_period", lat, Lat);
      check("cont_count", freq_count, 32'd50);
    end
    step();
    check("cont_busy_after", 32'(busy), 32'd0);
    count_valids(50, nvalid);
    check("cont_stopped", nvalid, 32'd0);

    // Saturation on the 4-bit instance, then a clean window clears overflow.
    pat_period = 10;
    pat_high = 5;
    settle();
    sat_start = 1'b1;
    lat = 0;
    for (int unsigned k = 1; k <= Lat + 100; k++) begin
      step();
      sat_start = 1'b0;
      if (sat_valid) begin
        lat = k;
        break;
      end
    end
    check("sat_latency", lat, Lat);
    check("sat_count", 32'(sat_count), 32'd15);
    check("sat_overflow", 32'(sat_ovf), 32'd1);
    pat_mode = 0;
    settle();
    sat_start = 1'b1;
    lat = 0;
    for (int unsigned k = 1; k <= Lat + 100; k++) begin
      step();
      sat_start = 1'b0;
      if (sat_valid) begin
        lat = k;
        break;
      end
    end
    check("sat_clear_latency", lat, Lat);
    check("sat_clear_count", 32'(sat_count), 32'd0);
    check("sat_clear_overflow", 32'(sat_ovf), 32'd0);

    // Reset at gate cycle 500 (main instance holds 50 from continuous mode).
    pat_mode = 1;
    settle();
    start = 1'b1;
    run_until_valid(501, 0, 0, lat, npulse);
    check("rstmid_no_early_valid", lat, 32'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rstmid_busy", 32'(busy), 32'd0);
    check("rstmid_count", freq_count, 32'd0);
    check("rstmid_overflow", 32'(overflow), 32'd0);
    count_valids(Lat + 50, nvalid);
    check("rstmid_no_valid", nvalid, 32'd0);

    // Constant-low input; a start during the gate is ignored.
    pat_mode = 0;
    settle();
    start = 1'b1;
    run_until_valid(Lat + 100, 301, 0, lat, npulse);
    check("idle_latency", lat, Lat);
    check("idle_count", freq_count, 32'd0);
    step();
    check("idle_busy_after", 32'(busy), 32'd0);
    count_valids(Lat + 10, nvalid);
    check("idle_start_not_queued", nvalid, 32'd0);

    // Period-10 input with a 2-cycle glitch in every low phase.
    pat_mode = 2;
    settle();
`ifdef SLOW_CLK_METER_FILTER_EN
    expct = 100;
`else
    expct = 200;
`endif
    start = 1'b1;
    run_until_valid(Lat + 100, 0, 0, lat, npulse);
    check("glitch_latency", lat, Lat);
    check("glitch_count", freq_count, expct);
    check("glitch_edge_pulses", npulse, expct);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
